midi_cc_receiver: RTL and testbench

Receive-side MIDI parser for the theremin path, the counterpart of the MIDI volume sender. It consumes bytes strobed out of a UART receiver and decodes Control Change messages, including running status. It filters them by channel and keeps a latched volume register, so a downstream synth voice or display can follow the controller stream.

---
 rtl/midi_cc_receiver.sv | 165 ++++++++++++++++
 tb/tb_midi_cc_receiver.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_cc_receiver.sv
// MIDI Control Change receiver: parses a UART byte stream with running status,
// filters CC messages by channel, latches a volume controller and flags protocol errors.
module midi_cc_receiver #(
  parameter logic [3:0]  CHANNEL        = 4'd0,
  parameter bit          OMNI           = 1'b0,
  parameter logic [6:0]  VOLUME_CC      = 7'd7,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [6:0] cc_num,
  output logic [6:0] cc_value,
  output logic [3:0] cc_channel,
  output logic       cc_valid,
  output logic [6:0] volume,
  output logic       volume_updated,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    WAIT_D1 = 2'd2,
    WAIT_D2 = 2'd3
  } state_e;

  localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 32'd1;

  state_e      state_q, state_d;
  logic [7:0]  rs_q, rs_d;
  logic        rs_valid_q, rs_valid_d;
  logic [6:0]  d1_q, d1_d;
  logic        len2_q, len2_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [6:0]  cc_num_q, cc_num_d;
  logic [6:0]  cc_value_q, cc_value_d;
  logic [3:0]  cc_channel_q, cc_channel_d;
  logic        cc_valid_q, cc_valid_d;
  logic [6:0]  volume_q, volume_d;
  logic        volume_updated_q, volume_updated_d;
  logic        error_q, error_d;

  logic is_sys;
  logic is_status;
  logic is_data;

  function automatic logic is_accepted(input logic [7:0] status);
    return (status[7:4] == 4'hB) && (OMNI || (status[3:0] == CHANNEL));
  endfunction

  // Real-time bytes (F8-FF) fall into none of these classes and are invisible here.
  assign is_sys    = rx_valid && (rx_byte[7:3] == 5'b11110);
  assign is_status = rx_valid && rx_byte[7] && (rx_byte[7:4] != 4'hF);
  assign is_data   = rx_valid && !rx_byte[7];

  always_comb begin
    state_d          = state_q;
    rs_d             = rs_q;
    rs_valid_d       = rs_valid_q;
    d1_d             = d1_q;
    len2_d           = len2_q;
    tmo_cnt_d        = tmo_cnt_q;
    cc_num_d         = cc_num_q;
    cc_value_d       = cc_value_q;
    cc_channel_d     = cc_channel_q;
    cc_valid_d       = 1'b0;
    volume_d         = volume_q;
    volume_updated_d = 1'b0;
    error_d          = 1'b0;

    if (is_sys) begin
      rs_valid_d = 1'b0;
      state_d    = SKIP;
      tmo_cnt_d  = '0;
    end else if (is_status) begin
      rs_d       = rx_byte;
      rs_valid_d = 1'b1;
      len2_d     = (rx_byte[7:5] != 3'b110);
      state_d    = WAIT_D1;
      error_d    = (state_q == WAIT_D2);
      tmo_cnt_d  = '0;
    end else if (is_data) begin
      tmo_cnt_d = '0;
      case (state_q)
        IDLE: error_d = 1'b1;
        SKIP: error_d = 1'b0;
        WAIT_D1: begin
          if (!rs_valid_q) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            d1_d = rx_byte[6:0];
            if (len2_q) state_d = WAIT_D2;
          end
        end
        WAIT_D2: begin
          state_d = WAIT_D1;
          if (rs_valid_q && is_accepted(rs_q)) begin
            cc_num_d     = d1_q;
            cc_value_d   = rx_byte[6:0];
            cc_channel_d = rs_q[3:0];
            cc_valid_d   = 1'b1;
            if (d1_q == VOLUME_CC) begin
              volume_d         = rx_byte[6:0];
              volume_updated_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q == WAIT_D2) && (TIMEOUT_CYCLES != 32'd0)) begin
      // An arriving byte always pre-empts the terminal count, so this only runs on idle cycles.
      if (tmo_cnt_q == TMO_LAST) begin
        error_d   = 1'b1;
        state_d   = WAIT_D1;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      rs_q             <= '0;
      rs_valid_q       <= 1'b0;
      d1_q             <= '0;
      len2_q           <= 1'b0;
      tmo_cnt_q        <= '0;
      cc_num_q         <= '0;
      cc_value_q       <= '0;
      cc_channel_q     <= '0;
      cc_valid_q       <= 1'b0;
      volume_q         <= '0;
      volume_updated_q <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      rs_q             <= rs_d;
      rs_valid_q       <= rs_valid_d;
      d1_q             <= d1_d;
      len2_q           <= len2_d;
      tmo_cnt_q        <= tmo_cnt_d;
      cc_num_q         <= cc_num_d;
      cc_value_q       <= cc_value_d;
      cc_channel_q     <= cc_channel_d;
      cc_valid_q       <= cc_valid_d;
      volume_q         <= volume_d;
      volume_updated_q <= volume_updated_d;
      error_q          <= error_d;
    end
  end

  assign cc_num         = cc_num_q;
  assign cc_value       = cc_value_q;
  assign cc_channel     = cc_channel_q;
  assign cc_valid       = cc_valid_q;
  assign volume         = volume_q;
  assign volume_updated = volume_updated_q;
  assign error          = error_q;

endmodule

// File: tb/tb_midi_cc_receiver.sv
// Bench for midi_cc_receiver: four differently configured instances share one byte stream;
// directed scenarios use hand-derived values, the random run uses a message-level model.
module tb_midi_cc_receiver;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;

  logic [6:0] cc_num         [N];
  logic [6:0] cc_value       [N];
  logic [3:0] cc_channel     [N];
  logic       cc_valid       [N];
  logic [6:0] volume         [N];
  logic       volume_updated [N];
  logic       error          [N];

  int checks = 0;
  int errors = 0;

  // Instance configuration: 0 default, 1 omni on channel 5, 2 timeout 100, 3 channel 9 / CC10 / timeout 5
  int cfg_ch   [N] = '{0, 5, 0, 9};
  int cfg_omni [N] = '{0, 1, 0, 0};
  int cfg_vol  [N] = '{7, 7, 7, 10};
  int cfg_tmo  [N] = '{0, 0, 100, 5};

  always #5 clk = ~clk;

  midi_cc_receiver u_def (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .cc_num(cc_num[0]), .cc_value(cc_value[0]), .cc_channel(cc_channel[0]), .cc_valid(cc_valid[0]),
    .volume(volume[0]), .volume_updated(volume_updated[0]), .error(error[0])
  );

  midi_cc_receiver #(.CHANNEL(4'd5), .OMNI(1'b1)) u_omni (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .cc_num(cc_num[1]), .cc_value(cc_value[1]), .cc_channel(cc_channel[1]), .cc_valid(cc_valid[1]),
    .volume(volume[1]), .volume_updated(volume_updated[1]), .error(error[1])
  );

  midi_cc_receiver #(.TIMEOUT_CYCLES(32'd100)) u_tmo (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .cc_num(cc_num[2]), .cc_value(cc_value[2]), .cc_channel(cc_channel[2]), .cc_valid(cc_valid[2]),
    .volume(volume[2]), .volume_updated(volume_updated[2]), .error(error[2])
  );

  midi_cc_receiver #(.CHANNEL(4'd9), .VOLUME_CC(7'd10), .TIMEOUT_CYCLES(32'd5)) u_alt (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .cc_num(cc_num[3]), .cc_value(cc_value[3]), .cc_channel(cc_channel[3]), .cc_valid(cc_valid[3]),
    .volume(volume[3]), .volume_updated(volume_updated[3]), .error(error[3])
  );

  // Packed view {cc_num, cc_value, cc_channel, cc_valid, volume, volume_updated, error}
  function automatic logic [27:0] outs(input int i);
    return {cc_num[i], cc_value[i], cc_channel[i], cc_valid[i], volume[i], volume_updated[i], error[i]};
  endfunction

  // Message-level reference: current status (-1 = none), skipping flag, pending first data byte.
  int         m_status [N];
  bit         m_skip   [N];
  bit         m_part   [N];
  int         m_d1     [N];
  int         m_idle   [N];
  logic [6:0] e_num    [N];
  logic [6:0] e_val    [N];
  logic [3:0] e_ch     [N];
  logic       e_ccv    [N];
  logic [6:0] e_vol    [N];
  logic       e_vu     [N];
  logic       e_err    [N];

  function automatic logic [27:0] expected(input int i);
    return {e_num[i], e_val[i], e_ch[i], e_ccv[i], e_vol[i], e_vu[i], e_err[i]};
  endfunction

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int hi;
      int need;
      e_ccv[i] = 1'b0;
      e_vu[i]  = 1'b0;
      e_err[i] = 1'b0;
      if (rst) begin
        m_status[i] = -1; m_skip[i] = 1'b0; m_part[i] = 1'b0; m_d1[i] = 0; m_idle[i] = 0;
        e_num[i] = '0; e_val[i] = '0; e_ch[i] = '0; e_vol[i] = '0;
      end else if (rx_valid && rx_byte < 8'hF8) begin
        m_idle[i] = 0;
        if (rx_byte >= 8'hF0) begin
          m_status[i] = -1; m_skip[i] = 1'b1; m_part[i] = 1'b0;
        end else if (rx_byte >= 8'h80) begin
          if (m_part[i]) e_err[i] = 1'b1;
          m_status[i] = int'(rx_byte); m_skip[i] = 1'b0; m_part[i] = 1'b0;
        end else if (m_skip[i]) begin
          m_part[i] = 1'b0;
        end else if (m_status[i] < 0) begin
          e_err[i] = 1'b1;
        end else begin
          hi   = m_status[i] / 16;
          need = (hi == 12 || hi == 13) ? 1 : 2;
          if (need == 2 && !m_part[i]) begin
            m_d1[i]   = int'(rx_byte);
            m_part[i] = 1'b1;
          end else begin
            if (need == 2 && hi == 11 && (cfg_omni[i] != 0 || (m_status[i] % 16) == cfg_ch[i])) begin
              e_num[i] = 7'(m_d1[i]);
              e_val[i] = rx_byte[6:0];
              e_ch[i]  = 4'(m_status[i] % 16);
              e_ccv[i] = 1'b1;
              if (m_d1[i] == cfg_vol[i]) begin
                e_vol[i] = rx_byte[6:0];
                e_vu[i]  = 1'b1;
              end
            end
            m_part[i] = 1'b0;
          end
        end
      end else if (m_part[i] && cfg_tmo[i] > 0) begin
        m_idle[i]++;
        if (m_idle[i] == cfg_tmo[i]) begin
          e_err[i] = 1'b1; m_part[i] = 1'b0; m_idle[i] = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Drivers: called at a negedge, return at the next negedge with outputs of that byte visible.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (outs(i) !== 28'h0) begin
        errors++; $display("FAIL reset inst%0d got %h want %h", i, outs(i), 28'h0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_cc();
    logic [27:0] exp;
    send_byte(8'hB0);
    send_byte(8'h07);
    exp = 28'h0;
    checks++;
    if (outs(0) !== exp) begin errors++; $display("FAIL basic_pre got %h want %h", outs(0), exp); end
    send_byte(8'h64);
    exp = {7'd7, 7'd100, 4'd0, 1'b1, 7'd100, 1'b1, 1'b0};
    checks++;
    if (outs(0) !== exp) begin errors++; $display("FAIL basic_cc got %h want %h", outs(0), exp); end
    idle_cycles(1);
    exp = {7'd7, 7'd100, 4'd0, 1'b0, 7'd100, 1'b0, 1'b0};
    checks++;
    if (outs(0) !== exp) begin errors++; $display("FAIL basic_hold got %h want %h", outs(0), exp); end
  endtask

  task automatic test_running_status();
    logic [27:0] exp;
    send_byte(8'h07);
    send_byte(8'h7F);
    exp = {7'd7, 7'd127, 4'd0, 1'b1, 7'd127, 1'b1, 1'b0};
    checks++;
    if (outs(0) !== exp) begin errors++; $display("FAIL rs_first got %h want %h", outs(0), exp); end
    send_byte(8'h07);
    exp = {7'd7, 7'd127, 4'd0, 1'b0, 7'd127, 1'b0, 1'b0};
    checks++;
    if (outs(0) !== exp) begin errors++; $display("FAIL rs_gap got %h want %h", outs(0), exp); end
    send_byte(8'h00);
    exp = {7'd7, 7'd0, 4'd0, 1'b1, 7'd0, 1'b1, 1'b0};
    checks++;
    if (outs(0) !== exp) begin errors++; $display("FAIL rs_second got %h want %h", outs(0), exp); end
    idle_cycles(1);
  endtask

  task automatic test_channel_filter();
    logic [27:0] exp;
    send_byte(8'hB3);
    send_byte(8'h07);
    send_byte(8'h40);
    exp = {7'd7, 7'd0, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0};
    checks++;
    if (outs(0) !== exp) begin errors++; $display("FAIL filter_ch0 got %h want %h", outs(0), exp); end
    exp = {7'd7, 7'h40, 4'd3, 1'b1, 7'h40, 1'b1, 1'b0};
    checks++;
    if (outs(1) !== exp) begin errors++; $display("FAIL filter_omni got %h want %h", outs(1), exp); end
    idle_cycles(1);
  endtask

  task automatic test_interleave();
    logic [27:0] exp;
    logic [7:0]  seq_a [4] = '{8'hB0, 8'hF8, 8'h07, 8'hFE};
    logic [7:0]  seq_b [5] = '{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h07};
    exp = {7'd7, 7'd0, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0};
    foreach (seq_a[k]) begin
      send_byte(seq_a[k]);
      checks++;
      if (outs(0) !== exp) begin errors++; $display("FAIL rt_mid%0d got %h want %h", k, outs(0), exp); end
    end
    send_byte(8'h20);
    exp = {7'd7, 7'h20, 4'd0, 1'b1, 7'h20, 1'b1, 1'b0};
    checks++;
    if (outs(0) !== exp) begin errors++; $display("FAIL rt_cc got %h want %h", outs(0), exp); end
    exp = {7'd7, 7'h20, 4'd0, 1'b0, 7'h20, 1'b0, 1'b0};
    foreach (seq_b[k]) begin
      send_byte(seq_b[k]);
      checks++;
      if (outs(0) !== exp) begin errors++; $display("FAIL sysex%0d got %h want %h", k, outs(0), exp); end
    end
    idle_cycles(1);
  endtask

  task automatic test_errors();
    logic [27:0] err_only;
    logic [7:0]  seq [5] = '{8'hB0, 8'h07, 8'h90, 8'h3C, 8'h64};
    err_only = 28'h1;
    pulse_reset();
    send_byte(8'h40);
    checks++;
    if (outs(0) !== err_only) begin errors++; $display("FAIL err_idle got %h want %h", outs(0), err_only); end
    idle_cycles(1);
    checks++;
    if (outs(0) !== 28'h0) begin errors++; $display("FAIL err_pulse got %h want %h", outs(0), 28'h0); end
    foreach (seq[k]) begin
      send_byte(seq[k]);
      checks++;
      if (outs(0) !== ((k == 2) ? err_only : 28'h0)) begin
        errors++; $display("FAIL err_partial%0d got %h want %h", k, outs(0), (k == 2) ? err_only : 28'h0);
      end
    end
    send_byte(8'hB0);
    send_byte(8'h07);
    pulse_reset();
    send_byte(8'h64);
    checks++;
    if (outs(0) !== err_only) begin errors++; $display("FAIL err_rst_mid got %h want %h", outs(0), err_only); end
    idle_cycles(1);
  endtask

  task automatic test_timeout();
    logic [27:0] exp;
    pulse_reset();
    send_byte(8'hB0);
    send_byte(8'h07);
    for (int k = 1; k <= 102; k++) begin
      idle_cycles(1);
      checks++;
      if (error[2] !== (k == 100)) begin
        errors++; $display("FAIL tmo_err cycle%0d got %b want %b", k, error[2], (k == 100));
      end
    end
    send_byte(8'h07);
    send_byte(8'h55);
    exp = {7'd7, 7'h55, 4'd0, 1'b1, 7'h55, 1'b1, 1'b0};
    checks++;
    if (outs(2) !== exp) begin errors++; $display("FAIL tmo_resume got %h want %h", outs(2), exp); end
    send_byte(8'h07);
    idle_cycles(99);
    send_byte(8'h33);
    exp = {7'd7, 7'h33, 4'd0, 1'b1, 7'h33, 1'b1, 1'b0};
    checks++;
    if (outs(2) !== exp) begin errors++; $display("FAIL tmo_terminal got %h want %h", outs(2), exp); end
    idle_cycles(1);
    checks++;
    if (error[2] !== 1'b0) begin errors++; $display("FAIL tmo_after got %b want 0", error[2]); end
  endtask

  task automatic test_random();
    int gap;
    int r;
    gap = 0;
    pulse_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (outs(i) !== expected(i)) begin
          errors++;
          if (errors < 20) $display("FAIL random cyc%0d inst%0d got %h want %h", cyc, i, outs(i), expected(i));
        end
      end
      rst = 1'b0;
      if (gap > 0) begin
        gap--;
        rx_valid = 1'b0;
      end else begin
        r = int'($urandom_range(0, 199));
        rx_valid = 1'b1;
        if (r < 50) begin
          case ($urandom_range(0, 3))
            0:       rx_byte = 8'hB0;
            1:       rx_byte = 8'hB9;
            2:       rx_byte = 8'hB3;
            default: rx_byte = 8'hB0 + 8'($urandom_range(0, 15));
          endcase
        end else if (r < 70) begin
          rx_byte = 8'($urandom_range(8'h80, 8'hEF));
        end else if (r < 140) begin
          case ($urandom_range(0, 3))
            0:       rx_byte = 8'h07;
            1:       rx_byte = 8'h0A;
            default: rx_byte = 8'($urandom_range(0, 127));
          endcase
        end else if (r < 160) begin
          rx_byte = 8'($urandom_range(8'hF8, 8'hFF));
        end else if (r < 170) begin
          rx_byte = 8'($urandom_range(8'hF0, 8'hF7));
        end else if (r < 196) begin
          rx_valid = 1'b0;
          gap = (r < 194) ? int'($urandom_range(0, 8)) : int'($urandom_range(95, 110));
        end else if (r < 198) begin
          rx_valid = 1'b0;
        end else begin
          rst = 1'b1;
          rx_valid = $urandom_range(0, 1) == 1;
          rx_byte = 8'($urandom_range(0, 255));
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    rx_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_cc();
    test_running_status();
    test_channel_filter();
    test_interleave();
    test_errors();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
